// File: rtl/cellrv32_package.sv
// Shared types for the vector writeback arbiter: request bundle, FSM state and
// default geometry of the vector register file port.
package cellrv32_package;

   localparam int VWB_NUM_REQ = 3;
   localparam int VWB_VREGS   = 32;
   localparam int VWB_LANES   = 8;
   localparam int VWB_DATA_W  = 32;
   localparam int VWB_ADDR_W  = $clog2(VWB_VREGS);

   typedef enum logic {
      VWB_IDLE   = 1'b0,
      VWB_LOCKED = 1'b1
   } vwb_state_e;

   typedef struct packed {
      logic                                   valid;
      logic                                   last;
      logic [VWB_ADDR_W-1:0]                  addr;
      logic [VWB_LANES-1:0]                   en;
      logic [VWB_LANES-1:0][VWB_DATA_W-1:0]   data;
   } vwb_req_t;

   // Index width for n requesters, never narrower than one bit.
   function automatic int vwb_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority selector: first set request at or above ptr_i (mod N) wins.
// Purely combinational; shared with the load/store read-port arbiter.
module rr_pick
   import cellrv32_package::*;
#(
   parameter int N  = 3,
   parameter int IW = vwb_idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   int cand;

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int i = 0; i < N; i++) begin
         cand = int'(ptr_i) + i;
         if (cand >= N) cand = cand - N;
         if (!valid_o && req_i[cand]) begin
            valid_o       = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/vwb_arbiter.sv
// Round-robin writeback arbiter with burst locking in front of the VRF write
// port; one beat per cycle, registered output with one cycle of latency.
module vwb_arbiter
   import cellrv32_package::*;
#(
   parameter  int NUM_REQ          = VWB_NUM_REQ,
   parameter  int VECTOR_REGISTERS = VWB_VREGS,
   parameter  int VECTOR_LANES     = VWB_LANES,
   parameter  int DATA_WIDTH       = VWB_DATA_W,
   localparam int AW               = $clog2(VECTOR_REGISTERS),
   localparam int IW               = vwb_idx_w(NUM_REQ)
) (
   input  logic                                             clk_i,
   input  logic                                             rst_i,
   input  logic [NUM_REQ-1:0]                               req_valid_i,
   output logic [NUM_REQ-1:0]                               req_ready_o,
   input  logic [NUM_REQ-1:0]                               req_last_i,
   input  logic [NUM_REQ-1:0][AW-1:0]                       req_addr_i,
   input  logic [NUM_REQ-1:0][VECTOR_LANES-1:0]             req_en_i,
   input  logic [NUM_REQ-1:0][VECTOR_LANES-1:0][DATA_WIDTH-1:0] req_data_i,
   output logic [VECTOR_LANES-1:0]                          wr_en_o,
   output logic [AW-1:0]                                    wr_addr_o,
   output logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0]          wr_data_o,
   output logic [IW-1:0]                                    owner_o,
   output logic                                             busy_o
);

   vwb_state_e                             state_q;
   logic [IW-1:0]                          owner_q;
   logic [IW-1:0]                          ptr_q;
   logic [IW-1:0]                          ptr_d;
   logic [VECTOR_LANES-1:0]                wr_en_q;
   logic [AW-1:0]                          wr_addr_q;
   logic [VECTOR_LANES-1:0][DATA_WIDTH-1:0] wr_data_q;

   logic [NUM_REQ-1:0] pick_req;
   logic [IW-1:0]      pick_ptr;
   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      win;
   logic               xfer;

   // While locked only the owner is visible to the picker, so other
   // requesters stay blocked even across owner bubble cycles.
   always_comb begin
      pick_req = req_valid_i;
      pick_ptr = ptr_q;
      if (state_q == VWB_LOCKED) begin
         pick_req          = '0;
         pick_req[owner_q] = req_valid_i[owner_q];
         pick_ptr          = owner_q;
      end
   end

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i   (pick_req),
      .ptr_i   (pick_ptr),
      .grant_o (grant),
      .idx_o   (win),
      .valid_o (xfer)
   );

   assign req_ready_o = grant;
   assign ptr_d       = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples the pre-edge values of its peers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= VWB_IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= '0;
         if (xfer) begin
            wr_en_q   <= req_en_i[win];
            wr_addr_q <= req_addr_i[win];
            wr_data_q <= req_data_i[win];
            owner_q   <= win;
            if (req_last_i[win]) begin
               state_q <= VWB_IDLE;
               ptr_q   <= ptr_d;
            end else begin
               state_q <= VWB_LOCKED;
            end
         end
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign owner_o   = owner_q;
   assign busy_o    = (state_q == VWB_LOCKED);

endmodule

// File: tb/tb_vwb_arbiter.sv
// Scoreboard bench for vwb_arbiter: per-requester beat queues drive the inputs,
// a reference arbiter predicts grants and the registered writeback stream.
module tb_vwb_arbiter;
   import cellrv32_package::*;

   localparam int N  = VWB_NUM_REQ;
   localparam int AW = VWB_ADDR_W;
   localparam int L  = VWB_LANES;
   localparam int DW = VWB_DATA_W;
   localparam int IW = vwb_idx_w(N);

   typedef struct packed {
      logic [L-1:0]         en;
      logic [AW-1:0]        addr;
      logic [L-1:0][DW-1:0] data;
      logic [IW-1:0]        owner;
      logic                 busy;
   } exp_t;

   logic                         clk = 1'b0;
   logic                         rst_i;
   logic [N-1:0]                 req_valid;
   logic [N-1:0]                 req_ready;
   logic [N-1:0]                 req_last;
   logic [N-1:0][AW-1:0]         req_addr;
   logic [N-1:0][L-1:0]          req_en;
   logic [N-1:0][L-1:0][DW-1:0]  req_data;
   logic [L-1:0]                 wr_en;
   logic [AW-1:0]                wr_addr;
   logic [L-1:0][DW-1:0]         wr_data;
   logic [IW-1:0]                owner;
   logic                         busy;

   vwb_req_t src_q [N][$];
   exp_t     exp_q [$];

   int n_total = 0;
   int n_bad   = 0;

   bit                   m_locked;
   int                   m_owner;
   int                   m_ptr;
   logic [AW-1:0]        m_addr;
   logic [L-1:0][DW-1:0] m_data;
   int                   wait_cnt [N];

   vwb_arbiter u_dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_last_i  (req_last),
      .req_addr_i  (req_addr),
      .req_en_i    (req_en),
      .req_data_i  (req_data),
      .wr_en_o     (wr_en),
      .wr_addr_o   (wr_addr),
      .wr_data_o   (wr_data),
      .owner_o     (owner),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic vwb_req_t mk_beat(input logic last, input logic [AW-1:0] addr,
                                        input logic [L-1:0] en, input logic [L-1:0][DW-1:0] data);
      vwb_req_t b;
      b.valid = 1'b1;
      b.last  = last;
      b.addr  = addr;
      b.en    = en;
      b.data  = data;
      return b;
   endfunction

   function automatic logic [L-1:0][DW-1:0] rand_data();
      logic [L-1:0][DW-1:0] d;
      for (int l = 0; l < L; l++) d[l] = $urandom;
      return d;
   endfunction

   task automatic model_reset();
      m_locked = 1'b0;
      m_owner  = 0;
      m_ptr    = 0;
      m_addr   = '0;
      m_data   = '0;
      for (int r = 0; r < N; r++) wait_cnt[r] = 0;
   endtask

   task automatic drive_inputs();
      for (int r = 0; r < N; r++) begin
         if (src_q[r].size() > 0) begin
            req_valid[r] = src_q[r][0].valid;
            req_last[r]  = src_q[r][0].last;
            req_addr[r]  = src_q[r][0].addr;
            req_en[r]    = src_q[r][0].en;
            req_data[r]  = src_q[r][0].data;
         end else begin
            req_valid[r] = 1'b0;
            req_last[r]  = 1'b0;
            req_addr[r]  = '0;
            req_en[r]    = '0;
            req_data[r]  = '0;
         end
      end
   endtask

   // One clock: check last cycle's registered output, present new beats,
   // predict the grant and queue the output it must produce next edge.
   task automatic cycle();
      exp_t         e;
      int           g;
      logic [N-1:0] exp_rdy;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("wr_en",   wr_en,   e.en);
         check("wr_addr", wr_addr, e.addr);
         check("wr_data", wr_data, e.data);
         check("owner",   owner,   e.owner);
         check("busy",    busy,    e.busy);
      end
      drive_inputs();
      #1;
      g = -1;
      if (m_locked) begin
         if (req_valid[m_owner]) g = m_owner;
      end else begin
         for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (g < 0 && req_valid[j]) g = j;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("ready", req_ready, exp_rdy);
      if (g >= 0) begin
         e.en    = req_en[g];
         m_addr  = req_addr[g];
         m_data  = req_data[g];
         m_owner = g;
         for (int r = 0; r < N; r++)
            if (r != g && req_valid[r] && req_last[g]) wait_cnt[r]++;
         check("starve", wait_cnt[g] <= N, 1);
         wait_cnt[g] = 0;
         if (req_last[g]) begin
            m_locked = 1'b0;
            m_ptr    = (g + 1) % N;
         end else begin
            m_locked = 1'b1;
         end
      end else begin
         e.en = '0;
      end
      e.addr  = m_addr;
      e.data  = m_data;
      e.owner = IW'(m_owner);
      e.busy  = m_locked;
      exp_q.push_back(e);
      for (int r = 0; r < N; r++)
         if (src_q[r].size() > 0 && (!src_q[r][0].valid || g == r)) void'(src_q[r].pop_front());
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((src_q[0].size() + src_q[1].size() + src_q[2].size()) > 0 && budget < 300) begin
         cycle();
         budget++;
      end
      check("drain_timeout", budget < 300, 1);
      cycle();
      cycle();
   endtask

   task automatic reset_dut();
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      for (int r = 0; r < N; r++) src_q[r].delete();
      model_reset();
      drive_inputs();
      check("rst_wr_en",   wr_en,   0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_owner",   owner,   0);
      check("rst_busy",    busy,    0);
      rst_i = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
      $fatal(1);
   end

   initial begin
      logic [L-1:0][DW-1:0] lane_idx;
      rst_i = 1'b1;
      model_reset();
      drive_inputs();
      repeat (2) @(posedge clk);
      reset_dut();

      // Single beat from req0 with lane-index data.
      for (int l = 0; l < L; l++) lane_idx[l] = DW'(l);
      src_q[0].push_back(mk_beat(1'b1, AW'(5), 8'hFF, lane_idx));
      drain();

      // Three simultaneous single beats from pointer 0: served 0,1,2.
      reset_dut();
      for (int r = 0; r < N; r++) src_q[r].push_back(mk_beat(1'b1, AW'(r), 8'hFF, rand_data()));
      drain();

      // req1 burst of 4 with an owner bubble; req0 waits the whole burst.
      for (int b = 0; b < 4; b++) begin
         if (b == 2) src_q[1].push_back('0);
         src_q[1].push_back(mk_beat(b == 3, AW'(8 + b), 8'hFF, rand_data()));
      end
      cycle();
      src_q[0].push_back(mk_beat(1'b1, AW'(20), 8'hA5, rand_data()));
      drain();

      // Partial and empty lane masks from req2.
      src_q[2].push_back(mk_beat(1'b1, AW'(3), 8'h0F, rand_data()));
      src_q[2].push_back(mk_beat(1'b1, AW'(4), 8'h00, rand_data()));
      drain();

      // Reset in the middle of a locked burst, then req2 from pointer 0.
      for (int b = 0; b < 4; b++)
         src_q[1].push_back(mk_beat(b == 3, AW'(12 + b), 8'hFF, rand_data()));
      cycle();
      cycle();
      reset_dut();
      src_q[2].push_back(mk_beat(1'b1, AW'(30), 8'h3C, rand_data()));
      drain();

      // Random traffic: bursts of 1..4 beats with bubbles and sparse masks.
      for (int c = 0; c < 10000; c++) begin
         for (int r = 0; r < N; r++) begin
            if (src_q[r].size() == 0 && $urandom_range(0, 3) == 0) begin
               int len;
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) begin
                  logic [L-1:0] en;
                  if ($urandom_range(0, 4) == 0) src_q[r].push_back('0);
                  en = ($urandom_range(0, 7) == 0) ? '0 : L'($urandom);
                  src_q[r].push_back(mk_beat(b == len - 1, AW'($urandom), en, rand_data()));
               end
            end
         end
         cycle();
      end
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
